fetch_buffer: RTL and testbench

Instruction fetch front end that sits directly upstream of the decode stage. It issues AXI4 read bursts starting at the current fetch PC and accepts the 64-bit read beats. Each beat is split into two 32-bit instructions, which are queued with their PCs in a FIFO. The decoder pops instructions through a valid/ready interface. A redirect input (branch or jump resolution) flushes queued and in-flight fetches and restarts fetching at a new PC.

---
 rtl/fetch_buffer_if.sv | 44 ++++
 rtl/fetch_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// AXI4 read-address/read-data channels plus the decode-side instruction handshake.
interface fetch_buffer_if #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] inst_pc;

    // Fetch unit side.
    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    // Memory and decoder side.
    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: AXI4 burst reads split into 32-bit instructions,
// queued with their PCs, popped by the decoder, flushed on redirect.
module fetch_buffer #(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    fetch_buffer_if.master        bus
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned RESV = 2 * BURST_LEN;

    typedef enum logic [2:0] {BOOT, IDLE, ADDR, DATA, DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           word;
    } slot_t;

    state_t                state_q, state_nx;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_nx;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_nx;
    logic                  arvalid_q, rready_q;
    logic                  flush_q, flush_nx;
    logic [CW-1:0]         reserved_q, reserved_nx;
    logic [CW-1:0]         count_q, count_nx;
    logic [PW-1:0]         rd_q, rd_nx, wr_q, wr_nx, w1_ptr;
    slot_t                 mem [DEPTH];
    slot_t                 w0, w1, head_q, head_nx;
    logic                  inst_valid_q;
    logic [1:0]            push_n;
    logic                  flush_fifo, pop, rx;
    logic [ADDR_WIDTH-1:0] beat_base;
    logic [CW:0]           occupied;

    assign rx        = bus.m_axi_rvalid && rready_q;
    assign pop       = inst_valid_q && bus.inst_ready;
    assign beat_base = {fetch_pc_q[ADDR_WIDTH-1:3], 3'b000};
    assign occupied  = {1'b0, count_q} + {1'b0, reserved_q} + (CW+1)'(RESV);
    assign w1_ptr    = wr_q + PW'(1);

    // Next-state, fetch PC, reservation and beat-to-instruction split.
    always_comb begin
        state_nx    = state_q;
        fetch_pc_nx = fetch_pc_q;
        araddr_nx   = araddr_q;
        reserved_nx = reserved_q;
        flush_nx    = flush_q;
        flush_fifo  = 1'b0;
        push_n      = 2'd0;
        w0          = '0;
        w1          = '0;

        case (state_q)
            BOOT: begin
                fetch_pc_nx = entry;
                state_nx    = IDLE;
            end
            IDLE: begin
                if (!redirect_valid && occupied <= (CW+1)'(DEPTH)) begin
                    araddr_nx   = beat_base;
                    reserved_nx = CW'(RESV);
                    state_nx    = ADDR;
                end
            end
            ADDR: begin
                if (redirect_valid) begin
                    flush_nx = 1'b1;
                end
                if (bus.m_axi_arready) begin
                    state_nx = (flush_q || redirect_valid) ? DRAIN : DATA;
                    flush_nx = 1'b0;
                end
            end
            DATA: begin
                if (redirect_valid) begin
                    // A final beat arriving with the redirect closes the burst itself.
                    state_nx = (rx && bus.m_axi_rlast) ? IDLE : DRAIN;
                end else if (rx) begin
                    if (fetch_pc_q[2]) begin
                        push_n = 2'd1;
                        w0     = '{pc: beat_base + ADDR_WIDTH'(4),
                                   word: bus.m_axi_rdata[DATA_WIDTH-1:32]};
                    end else begin
                        push_n = 2'd2;
                        w0     = '{pc: beat_base, word: bus.m_axi_rdata[31:0]};
                        w1     = '{pc: beat_base + ADDR_WIDTH'(4),
                                   word: bus.m_axi_rdata[DATA_WIDTH-1:32]};
                    end
                    fetch_pc_nx = beat_base + ADDR_WIDTH'(8);
                    reserved_nx = reserved_q - CW'(push_n);
                    if (bus.m_axi_rlast) begin
                        reserved_nx = '0;
                        state_nx    = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (rx && bus.m_axi_rlast) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = BOOT;
        endcase

        if (redirect_valid && state_q != BOOT) begin
            fetch_pc_nx = redirect_pc;
            reserved_nx = '0;
            flush_fifo  = 1'b1;
        end
    end

    // Control state and registered AXI outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= '0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            reserved_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_nx;
            fetch_pc_q <= fetch_pc_nx;
            araddr_q   <= araddr_nx;
            arvalid_q  <= (state_nx == ADDR);
            rready_q   <= (state_nx == DATA) || (state_nx == DRAIN);
            reserved_q <= reserved_nx;
            flush_q    <= flush_nx;
        end
    end

    // Queue pointers and the next head, bypassing writes that land at the head slot.
    always_comb begin
        rd_nx    = rd_q + PW'(pop);
        wr_nx    = wr_q + PW'(push_n);
        count_nx = count_q + CW'(push_n) - CW'(pop);
        head_nx  = head_q;
        if (flush_fifo) begin
            rd_nx    = '0;
            wr_nx    = '0;
            count_nx = '0;
        end else if (count_nx != '0) begin
            if (push_n != 2'd0 && wr_q == rd_nx) begin
                head_nx = w0;
            end else if (push_n == 2'd2 && w1_ptr == rd_nx) begin
                head_nx = w1;
            end else begin
                head_nx = mem[rd_nx];
            end
        end
    end

    // Instruction storage.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            mem[wr_q] <= w0;
        end
        if (push_n == 2'd2) begin
            mem[w1_ptr] <= w1;
        end
    end

    // Queue state and registered head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            head_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            rd_q         <= rd_nx;
            wr_q         <= wr_nx;
            count_q      <= count_nx;
            head_q       <= head_nx;
            inst_valid_q <= (count_nx != '0);
        end
    end

    assign bus.m_axi_arid    = ID_WIDTH'(0);
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
    assign bus.m_axi_arsize  = 3'b011;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_rready  = rready_q;
    assign bus.inst_valid    = inst_valid_q;
    assign bus.inst          = head_q.word;
    assign bus.inst_pc       = head_q.pc;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: AXI slave model, PC-stream reference model and a pop scoreboard.
module tb_fetch_buffer;
    localparam int unsigned ID_WIDTH   = 13;
    localparam int unsigned ADDR_WIDTH = 64;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned BURST_LEN  = 8;
    localparam int unsigned DEPTH      = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_buffer_if #(.ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fetch_buffer #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .BURST_LEN(BURST_LEN), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bus(bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_tail;
    logic [63:0] ar_log[$];
    logic [63:0] burst_q[$];
    int          beat_idx = 0;
    bit          hold_ar  = 1'b0;
    bit          rand_mode = 1'b0;

    // Memory contents: word index relative to 0x1000, so the boot burst returns 0,1,2,...
    function automatic logic [31:0] word_at(input logic [63:0] pc);
        logic [63:0] w;
        w = pc >> 2;
        return w[31:0] - 32'h400;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // Reference model: after a restart at pc, the decoder sees pc, pc+4, pc+8, ...
    task automatic model_restart(input logic [63:0] pc);
        exp_q.delete();
        model_tail = pc;
        repeat (64) begin
            exp_q.push_back(model_tail);
            model_tail += 64'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        model_restart(pc);
        step();
        redirect_valid = 1'b0;
        check("flush_inst_valid", 64'(bus.inst_valid), 64'd0);
    endtask

    task automatic wait_pops(input int target, input string name);
        int b = 0;
        while (pops < target && b < 3000) begin
            step();
            b++;
        end
        check(name, 64'(pops >= target), 64'd1);
    endtask

    task automatic wait_ars(input int target, input string name);
        int b = 0;
        while (ar_log.size() < target && b < 3000) begin
            step();
            b++;
        end
        check(name, 64'(ar_log.size() >= target), 64'd1);
    endtask

    task automatic wait_beat(input int idx, input string name);
        int b = 0;
        while (!(burst_q.size() != 0 && beat_idx == idx) && b < 3000) begin
            step();
            b++;
        end
        check(name, 64'(beat_idx), 64'(idx));
    endtask

    task automatic pop_n(input int n);
        int target = pops + n;
        int b = 0;
        bus.inst_ready = 1'b1;
        while (pops < target && b < 1000) begin
            step();
            b++;
        end
        bus.inst_ready = 1'b0;
        check("pop_n_done", 64'(pops), 64'(target));
    endtask

    // AXI read slave: one burst at a time, beats carry the words at their addresses.
    initial begin
        bit          ar_hs, r_hs;
        logic [63:0] a;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rdata   = '0;
        forever begin
            @(negedge clk);
            ar_hs = reset && bus.m_axi_arvalid && bus.m_axi_arready;
            r_hs  = reset && bus.m_axi_rvalid && bus.m_axi_rready;
            @(posedge clk);
            #1;
            if (!reset) begin
                burst_q.delete();
                beat_idx          = 0;
                bus.m_axi_arready = 1'b0;
                bus.m_axi_rvalid  = 1'b0;
                bus.m_axi_rlast   = 1'b0;
            end else begin
                if (r_hs) begin
                    if (burst_q.size() == 0) begin
                        fail_event("r_beat_without_ar");
                    end else if (beat_idx == int'(BURST_LEN) - 1) begin
                        void'(burst_q.pop_front());
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                if (ar_hs) begin
                    check("ar_no_outstanding", 64'(burst_q.size()), 64'd0);
                    check("araddr_aligned", 64'(bus.m_axi_araddr[2:0]), 64'd0);
                    check("arlen", 64'(bus.m_axi_arlen), 64'(BURST_LEN - 1));
                    check("arsize", 64'(bus.m_axi_arsize), 64'd3);
                    check("arburst", 64'(bus.m_axi_arburst), 64'd1);
                    check("arid", 64'(bus.m_axi_arid), 64'd0);
                    burst_q.push_back(bus.m_axi_araddr);
                    ar_log.push_back(bus.m_axi_araddr);
                end
                bus.m_axi_arready = hold_ar ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
                if (burst_q.size() != 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                    a                = burst_q[0] + 64'(8 * beat_idx);
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rdata  = {word_at(a + 64'd4), word_at(a)};
                    bus.m_axi_rlast  = (beat_idx == int'(BURST_LEN) - 1);
                end else begin
                    bus.m_axi_rvalid = 1'b0;
                    bus.m_axi_rdata  = {$urandom, $urandom};
                    bus.m_axi_rlast  = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: compares every pop and checks head stability under backpressure.
    initial begin
        logic [63:0] e;
        logic        prev_ok = 1'b0;
        logic [63:0] prev_pc = '0;
        logic [31:0] prev_inst = '0;
        forever begin
            @(negedge clk);
            if (prev_ok && reset) begin
                check("hold_valid", 64'(bus.inst_valid), 64'd1);
                check("hold_pc", bus.inst_pc, prev_pc);
                check("hold_inst", 64'(bus.inst), 64'(prev_inst));
            end
            if (reset && bus.inst_valid && bus.inst_ready && !redirect_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    fail_event("pop_without_expectation");
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", bus.inst_pc, e);
                    check("inst", 64'(bus.inst), 64'(word_at(e)));
                    exp_q.push_back(model_tail);
                    model_tail += 64'd4;
                end
            end
            prev_ok   = reset && bus.inst_valid && !bus.inst_ready && !redirect_valid;
            prev_pc   = bus.inst_pc;
            prev_inst = bus.inst;
        end
    end

    // Watchdog.
    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: run still active, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Directed phases followed by a randomized phase.
    initial begin
        logic [63:0] held_addr;
        int          n;

        reset          = 1'b0;
        entry          = 64'h1000;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.inst_ready = 1'b0;
        model_restart(64'h1000);
        repeat (3) step();
        check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("rst_araddr", bus.m_axi_araddr, 64'd0);
        check("rst_rready", 64'(bus.m_axi_rready), 64'd0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'd0);
        check("rst_inst_pc", bus.inst_pc, 64'd0);

        // Boot fetch.
        reset = 1'b1;
        step();
        check("boot_arvalid_cycle1", 64'(bus.m_axi_arvalid), 64'd0);
        step();
        check("boot_arvalid_cycle2", 64'(bus.m_axi_arvalid), 64'd1);
        check("boot_araddr", bus.m_axi_araddr, 64'h1000);
        bus.inst_ready = 1'b1;
        wait_pops(16, "boot_16_pops");
        check("boot_ar0", ar_log[0], 64'h1000);

        // Misaligned redirect from IDLE with a full queue.
        bus.inst_ready = 1'b0;
        repeat (100) step();
        n = ar_log.size();
        do_redirect(64'h2004);
        bus.inst_ready = 1'b1;
        wait_ars(n + 1, "misalign_ar_seen");
        check("misalign_araddr", ar_log[n], 64'h2000);
        wait_pops(pops + 15, "misalign_15_pops");

        // Redirect in the middle of a burst.
        wait_beat(3, "midburst_beat3");
        n = ar_log.size();
        do_redirect(64'h3000);
        wait_ars(n + 1, "midburst_next_ar");
        check("midburst_araddr", ar_log[n], 64'h3000);
        wait_pops(pops + 20, "midburst_pops");

        // Redirect while the address phase is stalled.
        hold_ar = 1'b1;
        n = 0;
        while (!(bus.m_axi_arvalid && !bus.m_axi_arready) && n < 500) begin
            step();
            n++;
        end
        check("addr_stall_reached", 64'(bus.m_axi_arvalid), 64'd1);
        held_addr = bus.m_axi_araddr;
        do_redirect(64'h4000);
        repeat (5) begin
            check("addr_hold_arvalid", 64'(bus.m_axi_arvalid), 64'd1);
            check("addr_hold_araddr", bus.m_axi_araddr, held_addr);
            step();
        end
        n = ar_log.size();
        hold_ar = 1'b0;
        wait_ars(n + 2, "addr_two_ars");
        check("addr_stale_ar", ar_log[n], held_addr);
        check("addr_new_ar", ar_log[n + 1], 64'h4000);
        wait_pops(pops + 20, "addr_pops");

        // Backpressure: two bursts fill the queue; the third waits for 16 free slots.
        bus.inst_ready = 1'b0;
        repeat (100) step();
        n = ar_log.size();
        do_redirect(64'h5000);
        repeat (200) step();
        check("bp_two_bursts", 64'(ar_log.size() - n), 64'd2);
        check("bp_ar0", ar_log[n], 64'h5000);
        check("bp_ar1", ar_log[n + 1], 64'h5040);
        pop_n(15);
        repeat (60) step();
        check("bp_still_two", 64'(ar_log.size() - n), 64'd2);
        pop_n(1);
        repeat (60) step();
        check("bp_third_burst", 64'(ar_log.size() - n), 64'd3);
        check("bp_ar2", ar_log[n + 2], 64'h5080);

        // Asynchronous reset in the middle of a data phase.
        bus.inst_ready = 1'b1;
        wait_beat(2, "reset_in_data");
        #3;
        reset = 1'b0;
        #1;
        check("areset_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("areset_araddr", bus.m_axi_araddr, 64'd0);
        check("areset_rready", 64'(bus.m_axi_rready), 64'd0);
        check("areset_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("areset_inst", 64'(bus.inst), 64'd0);
        check("areset_inst_pc", bus.inst_pc, 64'd0);
        entry = 64'h7000;
        repeat (3) step();
        n = ar_log.size();
        model_restart(64'h7000);
        reset = 1'b1;
        wait_ars(n + 1, "restart_ar");
        check("restart_araddr", ar_log[n], 64'h7000);
        wait_pops(pops + 20, "restart_pops");

        // Randomized traffic, backpressure and redirects.
        rand_mode = 1'b1;
        repeat (1500) begin
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                do_redirect(64'h8000 + 64'(4 * $urandom_range(0, 4095)));
            end else begin
                step();
            end
        end
        rand_mode      = 1'b0;
        bus.inst_ready = 1'b1;
        n = pops;
        wait_pops(n + 16, "final_pops");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
